// File: rtl/refpb_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | refpb_responder_pkg                                                  |
// | Shared command encoding, bank address width and responder states.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package refpb_responder_pkg;

   localparam int unsigned BK_ADDR_WIDTH = 4;

   typedef enum logic [3:0] {
      CMD_NOP1  = 4'h0,
      CMD_ACT   = 4'h1,
      CMD_RD    = 4'h2,
      CMD_WR    = 4'h3,
      CMD_PREPB = 4'h4,
      CMD_PREAB = 4'h5,
      CMD_REFPB = 4'h6,
      CMD_REFAB = 4'h7
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRAIN    = 3'd1,
      ST_PRE      = 3'd2,
      ST_WAIT_RP  = 3'd3,
      ST_REF      = 3'd4,
      ST_WAIT_RFC = 3'd5
   } refpb_rsp_state_t;

endpackage : refpb_responder_pkg
`default_nettype wire

// File: rtl/bk_pre_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bk_pre_tracker                                                       |
// | Open/closed tracker and tRP countdown for one bank, fed by the      |
// | arbiter command broadcast.                                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bk_pre_tracker
   import refpb_responder_pkg::*;
#(
   parameter int unsigned BK_ID = 0,
   parameter int unsigned TW    = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   input  cmd_t                     cmd,
   input  logic [BK_ADDR_WIDTH-1:0] cmd_bk,
   input  logic [TW-1:0]            t_rp,
   output logic                     open,
   output logic [TW-1:0]            pre_cnt,
   output logic                     act_hit
);

   localparam logic [BK_ADDR_WIDTH-1:0] c_bk  = BK_ADDR_WIDTH'(BK_ID);
   localparam logic [TW-1:0]            c_one = TW'(1);

   logic          w_bk_match;
   logic          w_pre_hit;
   logic [TW-1:0] w_t_rp_eff;
   logic          r_open;
   logic [TW-1:0] r_pre_cnt;

   assign w_bk_match = (cmd_bk == c_bk);
   assign act_hit    = cmd_valid && (cmd == CMD_ACT) && w_bk_match;
   assign w_pre_hit  = cmd_valid && (((cmd == CMD_PREPB) && w_bk_match) || (cmd == CMD_PREAB));
   assign w_t_rp_eff = (t_rp == '0) ? c_one : t_rp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_open    <= 1'b0;
         r_pre_cnt <= '0;
      end else begin
         if (act_hit) begin
            r_open <= 1'b1;
         end else if (w_pre_hit) begin
            r_open <= 1'b0;
         end
         // Any precharge of this bank restarts tRP, even one issued by someone else.
         if (w_pre_hit) begin
            r_pre_cnt <= w_t_rp_eff;
         end else if (r_pre_cnt != '0) begin
            r_pre_cnt <= r_pre_cnt - c_one;
         end
      end
   end

   assign open    = r_open;
   assign pre_cnt = r_pre_cnt;

endmodule : bk_pre_tracker
`default_nettype wire

// File: rtl/refpb_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | refpb_responder                                                      |
// | Per-bank REFPB responder: hold, drain, precharge, refresh, tRFCpb.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module refpb_responder
   import refpb_responder_pkg::*;
#(
   parameter int unsigned BK_ID = 0,
   parameter int unsigned TW    = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     refpb_req,
   output logic                     refpb_ack,
   output logic                     bke_hold,
   input  logic                     bke_idle,
   input  logic [TW-1:0]            t_rp,
   input  logic [TW-1:0]            t_rfcpb,
   output logic                     rsp_pkt_req,
   output cmd_t                     rsp_cmd,
   input  logic                     bkarb_pkt_ack,
   input  logic                     bkarb_cmd_valid,
   input  cmd_t                     bkarb_cmd,
   input  logic [BK_ADDR_WIDTH-1:0] bkarb_cmd_bk,
   output logic                     busy
);

   localparam logic [TW-1:0] c_one = TW'(1);

   logic             w_open;
   logic [TW-1:0]    w_pre_cnt;
   logic             w_act_hit;
   logic [TW-1:0]    w_t_rfc_eff;

   refpb_rsp_state_t r_state;
   logic [TW-1:0]    r_rfc_cnt;
   logic             r_refpb_ack;
   logic             r_bke_hold;
   logic             r_rsp_pkt_req;
   cmd_t             r_rsp_cmd;
   logic             r_busy;

   bk_pre_tracker #(
      .BK_ID (BK_ID),
      .TW    (TW)
   ) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (bkarb_cmd_valid),
      .cmd       (bkarb_cmd),
      .cmd_bk    (bkarb_cmd_bk),
      .t_rp      (t_rp),
      .open      (w_open),
      .pre_cnt   (w_pre_cnt),
      .act_hit   (w_act_hit)
   );

   assign w_t_rfc_eff = (t_rfcpb == '0) ? c_one : t_rfcpb;

   // Outputs are set on the edge that enters a state, so a closed bank reaches REFPB in 3 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_rfc_cnt     <= '0;
         r_refpb_ack   <= 1'b0;
         r_bke_hold    <= 1'b0;
         r_rsp_pkt_req <= 1'b0;
         r_rsp_cmd     <= CMD_NOP1;
         r_busy        <= 1'b0;
      end else begin
         r_refpb_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (refpb_req) begin
                  r_state    <= ST_DRAIN;
                  r_bke_hold <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!refpb_req) begin
                  r_state       <= ST_IDLE;
                  r_bke_hold    <= 1'b0;
                  r_busy        <= 1'b0;
                  r_rsp_pkt_req <= 1'b0;
                  r_rsp_cmd     <= CMD_NOP1;
               end else if (bke_idle) begin
                  if (w_open) begin
                     r_state       <= ST_PRE;
                     r_rsp_pkt_req <= 1'b1;
                     r_rsp_cmd     <= CMD_PREPB;
                  end else begin
                     r_state <= ST_WAIT_RP;
                  end
               end
            end
            ST_PRE: begin
               // An ack wins over a simultaneous request drop.
               if (bkarb_pkt_ack) begin
                  r_state       <= ST_WAIT_RP;
                  r_rsp_pkt_req <= 1'b0;
                  r_rsp_cmd     <= CMD_NOP1;
               end else if (!refpb_req) begin
                  r_state       <= ST_IDLE;
                  r_bke_hold    <= 1'b0;
                  r_busy        <= 1'b0;
                  r_rsp_pkt_req <= 1'b0;
                  r_rsp_cmd     <= CMD_NOP1;
               end
            end
            ST_WAIT_RP: begin
               if (!refpb_req) begin
                  r_state       <= ST_IDLE;
                  r_bke_hold    <= 1'b0;
                  r_busy        <= 1'b0;
                  r_rsp_pkt_req <= 1'b0;
                  r_rsp_cmd     <= CMD_NOP1;
               end else if (w_act_hit) begin
                  r_state       <= ST_PRE;
                  r_rsp_pkt_req <= 1'b1;
                  r_rsp_cmd     <= CMD_PREPB;
               end else if ((w_pre_cnt == '0) && !w_open) begin
                  r_state       <= ST_REF;
                  r_rsp_pkt_req <= 1'b1;
                  r_rsp_cmd     <= CMD_REFPB;
               end
            end
            ST_REF: begin
               if (bkarb_pkt_ack) begin
                  r_state       <= ST_WAIT_RFC;
                  r_refpb_ack   <= 1'b1;
                  r_rfc_cnt     <= w_t_rfc_eff;
                  r_rsp_pkt_req <= 1'b0;
                  r_rsp_cmd     <= CMD_NOP1;
               end else if (!refpb_req) begin
                  r_state       <= ST_IDLE;
                  r_bke_hold    <= 1'b0;
                  r_busy        <= 1'b0;
                  r_rsp_pkt_req <= 1'b0;
                  r_rsp_cmd     <= CMD_NOP1;
               end
            end
            ST_WAIT_RFC: begin
               if (r_rfc_cnt != '0) begin
                  r_rfc_cnt <= r_rfc_cnt - c_one;
               end
               if (r_rfc_cnt <= c_one) begin
                  r_state    <= ST_IDLE;
                  r_bke_hold <= 1'b0;
                  r_busy     <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_bke_hold    <= 1'b0;
               r_busy        <= 1'b0;
               r_rsp_pkt_req <= 1'b0;
               r_rsp_cmd     <= CMD_NOP1;
            end
         endcase
      end
   end

   assign refpb_ack   = r_refpb_ack;
   assign bke_hold    = r_bke_hold;
   assign rsp_pkt_req = r_rsp_pkt_req;
   assign rsp_cmd     = r_rsp_cmd;
   assign busy        = r_busy;

endmodule : refpb_responder
`default_nettype wire

// File: tb/tb_refpb_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_refpb_responder                                                   |
// | Directed stimulus with a scoreboard of expected arbiter requests.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_refpb_responder;
   import refpb_responder_pkg::*;

   localparam int unsigned BK = 3;
   localparam int unsigned TW = 10;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     refpb_req;
   logic                     refpb_ack;
   logic                     bke_hold;
   logic                     bke_idle;
   logic [TW-1:0]            t_rp;
   logic [TW-1:0]            t_rfcpb;
   logic                     rsp_pkt_req;
   cmd_t                     rsp_cmd;
   logic                     bkarb_pkt_ack;
   logic                     bkarb_cmd_valid;
   cmd_t                     bkarb_cmd;
   logic [BK_ADDR_WIDTH-1:0] bkarb_cmd_bk;
   logic                     busy;

   int checks = 0;
   int errors = 0;
   int last_wait = 0;

   typedef struct {
      bit   is_ack;
      cmd_t cmd;
   } tok_t;
   tok_t exp_q[$];

   logic m_prev_req = 1'b0;
   cmd_t m_exp_cmd  = CMD_NOP1;

   refpb_responder #(
      .BK_ID (BK),
      .TW    (TW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .refpb_req       (refpb_req),
      .refpb_ack       (refpb_ack),
      .bke_hold        (bke_hold),
      .bke_idle        (bke_idle),
      .t_rp            (t_rp),
      .t_rfcpb         (t_rfcpb),
      .rsp_pkt_req     (rsp_pkt_req),
      .rsp_cmd         (rsp_cmd),
      .bkarb_pkt_ack   (bkarb_pkt_ack),
      .bkarb_cmd_valid (bkarb_cmd_valid),
      .bkarb_cmd       (bkarb_cmd),
      .bkarb_cmd_bk    (bkarb_cmd_bk),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_tok(input bit a, input cmd_t c);
      tok_t t;
      t.is_ack = a;
      t.cmd    = c;
      exp_q.push_back(t);
   endtask

   // Scoreboard pop: one expected token per request rise or ack pulse.
   task automatic sb_pop(input bit a, input cmd_t c);
      tok_t t;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected: got ack=%0d cmd=%0d with nothing expected", a, c);
      end else begin
         t = exp_q.pop_front();
         if (t.is_ack != a || t.cmd != c) begin
            errors++;
            $display("FAIL sb_event: got ack=%0d cmd=%0d expected ack=%0d cmd=%0d",
                     a, c, t.is_ack, t.cmd);
         end
         if (!a) m_exp_cmd = t.cmd;
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         m_prev_req = 1'b0;
      end else begin
         if (rsp_pkt_req && !m_prev_req) sb_pop(1'b0, rsp_cmd);
         else if (rsp_pkt_req) chk("cmd_stable", rsp_cmd, m_exp_cmd);
         if (refpb_ack) sb_pop(1'b1, CMD_NOP1);
         m_prev_req = rsp_pkt_req;
      end
   end

   task automatic bcast(input cmd_t c, input int unsigned bk);
      bkarb_cmd_valid = 1'b1;
      bkarb_cmd       = c;
      bkarb_cmd_bk    = BK_ADDR_WIDTH'(bk);
      tick(1);
      bkarb_cmd_valid = 1'b0;
      bkarb_cmd       = CMD_NOP1;
   endtask

   // Arbiter: wait for the request, then ack and broadcast in the same cycle.
   task automatic grant(input cmd_t c, input bit drop);
      last_wait = 0;
      while (!rsp_pkt_req && last_wait < 60) begin
         tick(1);
         last_wait++;
      end
      if (!rsp_pkt_req) begin
         checks++;
         errors++;
         $display("FAIL grant_timeout: rsp_pkt_req=0 after %0d cycles, required 1", last_wait);
      end else begin
         bkarb_pkt_ack   = 1'b1;
         bkarb_cmd_valid = 1'b1;
         bkarb_cmd       = c;
         bkarb_cmd_bk    = BK_ADDR_WIDTH'(BK);
         if (drop) refpb_req = 1'b0;
         tick(1);
         bkarb_pkt_ack   = 1'b0;
         bkarb_cmd_valid = 1'b0;
         bkarb_cmd       = CMD_NOP1;
      end
   endtask

   task automatic req_latency(output int n, output int h1);
      refpb_req = 1'b1;
      tick(1);
      n  = 1;
      h1 = int'(bke_hold);
      while (!rsp_pkt_req && n < 30) begin
         tick(1);
         n++;
      end
   endtask

   task automatic wait_idle(input string name, input int lim);
      int n = 0;
      while (busy && n < lim) begin
         tick(1);
         n++;
      end
      chk(name, int'(busy), 0);
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_ack"},  int'(refpb_ack), 0);
      chk({pfx, "_hold"}, int'(bke_hold), 0);
      chk({pfx, "_req"},  int'(rsp_pkt_req), 0);
      chk({pfx, "_cmd"},  int'(rsp_cmd), int'(CMD_NOP1));
      chk({pfx, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, h1, bad_req, lo_hold;
      refpb_req       = 1'b0;
      bke_idle        = 1'b1;
      t_rp            = TW'(4);
      t_rfcpb         = TW'(20);
      bkarb_pkt_ack   = 1'b0;
      bkarb_cmd_valid = 1'b0;
      bkarb_cmd       = CMD_NOP1;
      bkarb_cmd_bk    = '0;
      tick(3);
      chk_reset("reset");
      rst = 1'b0;
      tick(2);

      // Closed bank (ACT on another bank must not open it).
      bcast(CMD_ACT, 5);
      expect_tok(1'b0, CMD_REFPB);
      expect_tok(1'b1, CMD_NOP1);
      req_latency(n, h1);
      chk("t1_latency", n, 3);
      chk("t1_hold_rise", h1, 1);
      grant(CMD_REFPB, 1'b1);
      chk("t1_ack_pulse", int'(refpb_ack), 1);
      n = 0;
      while (bke_hold && n < 100) begin
         n++;
         tick(1);
      end
      chk("t1_hold_len", n, 20);
      chk("t1_busy_end", int'(busy), 0);

      // Open bank: PREPB then REFPB at least tRP after the PREPB broadcast.
      t_rp    = TW'(6);
      t_rfcpb = TW'(5);
      bcast(CMD_ACT, BK);
      expect_tok(1'b0, CMD_PREPB);
      expect_tok(1'b0, CMD_REFPB);
      expect_tok(1'b1, CMD_NOP1);
      refpb_req = 1'b1;
      grant(CMD_PREPB, 1'b0);
      grant(CMD_REFPB, 1'b1);
      chk("t2_trp_gap_ok", int'((last_wait + 1) >= 6), 1);
      wait_idle("t2_idle", 20);

      // Engine not idle for 10 cycles.
      bke_idle  = 1'b0;
      refpb_req = 1'b1;
      bad_req   = 0;
      lo_hold   = 0;
      repeat (10) begin
         tick(1);
         if (rsp_pkt_req) bad_req++;
         if (!bke_hold) lo_hold++;
      end
      chk("t3_no_req_cycles", bad_req, 0);
      chk("t3_hold_low_cycles", lo_hold, 0);
      bke_idle = 1'b1;
      expect_tok(1'b0, CMD_REFPB);
      expect_tok(1'b1, CMD_NOP1);
      grant(CMD_REFPB, 1'b1);
      wait_idle("t3_idle", 20);

      // Request dropped while PREPB is pending.
      bcast(CMD_ACT, BK);
      expect_tok(1'b0, CMD_PREPB);
      refpb_req = 1'b1;
      n = 0;
      while (!rsp_pkt_req && n < 30) begin
         tick(1);
         n++;
      end
      chk("t4_pre_req", int'(rsp_pkt_req), 1);
      refpb_req = 1'b0;
      tick(1);
      chk("t4_hold", int'(bke_hold), 0);
      chk("t4_req", int'(rsp_pkt_req), 0);
      chk("t4_busy", int'(busy), 0);

      // Bank still open: PREAB reload in WAIT_RP, then late ACT forces a second PREPB.
      expect_tok(1'b0, CMD_PREPB);
      expect_tok(1'b0, CMD_PREPB);
      expect_tok(1'b0, CMD_REFPB);
      expect_tok(1'b1, CMD_NOP1);
      refpb_req = 1'b1;
      grant(CMD_PREPB, 1'b0);
      tick(3);
      bcast(CMD_PREAB, 0);
      tick(4);
      chk("t5_preab_reload", int'(rsp_pkt_req), 0);
      bcast(CMD_ACT, BK);
      chk("t5_back_to_pre", int'(rsp_pkt_req), 1);
      grant(CMD_PREPB, 1'b0);
      grant(CMD_REFPB, 1'b1);
      wait_idle("t5_idle", 20);

      // Reset during WAIT_RFC, then a fresh request.
      t_rfcpb = TW'(20);
      expect_tok(1'b0, CMD_REFPB);
      expect_tok(1'b1, CMD_NOP1);
      req_latency(n, h1);
      grant(CMD_REFPB, 1'b1);
      tick(3);
      chk("t6_in_rfc", int'(bke_hold), 1);
      rst = 1'b1;
      tick(1);
      chk_reset("t6_rst");
      rst = 1'b0;
      expect_tok(1'b0, CMD_REFPB);
      expect_tok(1'b1, CMD_NOP1);
      req_latency(n, h1);
      chk("t6_latency", n, 3);
      chk("t6_hold_rise", h1, 1);
      grant(CMD_REFPB, 1'b1);
      wait_idle("t6_idle", 40);

      tick(2);
      chk("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_refpb_responder
`default_nettype wire
